keypad_emulator: RTL and testbench

Behavioural-synthesizable responder for the 4x4 keypad matrix scan interface. It sits on the keypad side of the scan bus in place of physical keys. It accepts a key index through a valid/ready handshake, closes that key's contact (with optional chatter) for a programmable time, then releases it and reports completion. Testbenches and on-board self-test use it to drive the keypad driver and calculator input path without a real keypad.

---
 rtl/keypad_pkg.sv | 39 +++
 rtl/keypad_emulator_cycle_timer.sv | 25 ++
 rtl/keypad_emulator.sv | 141 ++++++++++++++
 tb/tb_keypad_emulator.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared keypad state type, key mapping constants and code helpers
package keypad_pkg;

   localparam int NOT_PRESSED = 16;
   localparam int KEY_ROWS    = 4;
   localparam int KEY_COLS    = 4;

   // Keys 0..12 carry hex 1..D; the last three positions carry 0, E and F.
   localparam logic [3:0] KEY_IDX_ZERO = 4'd13;
   localparam logic [3:0] KEY_IDX_E    = 4'd14;
   localparam logic [3:0] KEY_IDX_F    = 4'd15;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BOUNCE  = 2'd1,
      PRESS   = 2'd2,
      RELEASE = 2'd3
   } kp_state_t;

   function automatic logic [7:0] key_to_code(input logic [3:0] k);
      logic [3:0] row_oh;
      logic [3:0] col_oh;
      row_oh = 4'b0001 << k[3:2];
      col_oh = 4'b0001 << k[1:0];
      return {row_oh, col_oh};
   endfunction

   function automatic logic [3:0] key_to_hex(input logic [3:0] k);
      logic [3:0] hex;
      if (k == KEY_IDX_ZERO)
         hex = 4'd0;
      else if (k >= KEY_IDX_E)
         hex = k;
      else
         hex = k + 4'd1;
      return hex;
   endfunction

endpackage

// File: rtl/keypad_emulator_cycle_timer.sv
// rtl/keypad_emulator_cycle_timer.sv - loadable down-counter that saturates at zero
module cycle_timer #(
   parameter int CNT_W = 27
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             expired
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (clear)
         r_count <= '0;
      else if (load)
         r_count <= load_val;
      else if (r_count != '0)
         r_count <= r_count - CNT_W'(1);
   end

   assign expired = (r_count == '0);

endmodule

// File: rtl/keypad_emulator.sv
// rtl/keypad_emulator.sv - 4x4 keypad contact emulator driven by a key-press handshake
module keypad_emulator
   import keypad_pkg::*;
#(
   parameter int CNT_W          = 27,
   parameter int HOLD_CYCLES    = 80_000_000,
   parameter int GAP_CYCLES     = 4_000_000,
   parameter int BOUNCE_TOGGLES = 0,
   parameter int BOUNCE_PERIOD  = 1000
) (
   input  logic       clk,
   input  logic       clear,
   input  logic       req_valid,
   input  logic [3:0] req_key,
   output logic       req_ready,
   input  logic [3:0] scan_output,
   output logic [3:0] scan_got,
   output logic       busy,
   output logic       done
);

   localparam int HOLD_EFF = (HOLD_CYCLES   < 1) ? 1 : HOLD_CYCLES;
   localparam int GAP_EFF  = (GAP_CYCLES    < 1) ? 1 : GAP_CYCLES;
   localparam int PER_EFF  = (BOUNCE_PERIOD < 1) ? 1 : BOUNCE_PERIOD;

   // Timer runs from limit-1 down to 0, so a phase lasts exactly limit cycles.
   localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_EFF - 1);
   localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_EFF - 1);
   localparam logic [CNT_W-1:0] PER_LD   = CNT_W'(PER_EFF - 1);
   localparam logic [CNT_W-1:0] TOG_INIT = CNT_W'(BOUNCE_TOGGLES);
   localparam bit               HAS_BOUNCE = (BOUNCE_TOGGLES > 0);

   kp_state_t        r_state;
   logic [3:0]       r_key;
   logic             r_contact;
   logic             r_busy;
   logic             r_done;
   logic [CNT_W-1:0] r_tog;

   logic             w_accept;
   logic             w_expired;
   logic             w_load;
   logic [CNT_W-1:0] w_load_val;
   logic             w_last_tog;

   assign w_accept   = req_valid && (r_state == IDLE);
   assign w_last_tog = (r_tog <= CNT_W'(1));

   always_comb begin
      w_load     = 1'b0;
      w_load_val = HOLD_LD;
      case (r_state)
         IDLE: begin
            w_load     = w_accept;
            w_load_val = HAS_BOUNCE ? PER_LD : HOLD_LD;
         end
         BOUNCE: begin
            w_load     = w_expired;
            w_load_val = w_last_tog ? HOLD_LD : PER_LD;
         end
         PRESS: begin
            w_load     = w_expired;
            w_load_val = GAP_LD;
         end
         default: begin
            w_load     = 1'b0;
            w_load_val = HOLD_LD;
         end
      endcase
   end

   cycle_timer #(
      .CNT_W    (CNT_W)
   ) u_timer (
      .clk      (clk),
      .clear    (clear),
      .load     (w_load),
      .load_val (w_load_val),
      .expired  (w_expired)
   );

   always_ff @(posedge clk) begin
      if (clear) begin
         r_state   <= IDLE;
         r_key     <= 4'd0;
         r_contact <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_tog     <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_key     <= req_key;
                  r_contact <= 1'b1;
                  r_busy    <= 1'b1;
                  r_tog     <= TOG_INIT;
                  r_state   <= HAS_BOUNCE ? BOUNCE : PRESS;
               end
            end
            BOUNCE: begin
               if (w_expired) begin
                  if (w_last_tog) begin
                     r_contact <= 1'b1;
                     r_state   <= PRESS;
                  end else begin
                     r_contact <= ~r_contact;
                     r_tog     <= r_tog - CNT_W'(1);
                  end
               end
            end
            PRESS: begin
               if (w_expired) begin
                  r_contact <= 1'b0;
                  r_state   <= RELEASE;
               end
            end
            RELEASE: begin
               if (w_expired) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= IDLE;
               end
            end
            default: begin
               r_contact <= 1'b0;
               r_busy    <= 1'b0;
               r_state   <= IDLE;
            end
         endcase
      end
   end

   // Passive switch: the sensed row follows the column drive with no register.
   assign scan_got  = (r_contact && scan_output[r_key[1:0]]) ? (4'b0001 << r_key[3:2]) : 4'b0000;
   assign req_ready = (r_state == IDLE);
   assign busy      = r_busy;
   assign done      = r_done;

endmodule

// File: tb/tb_keypad_emulator.sv
// tb/tb_keypad_emulator.sv - scoreboard bench for keypad_emulator
module tb_keypad_emulator;
   import keypad_pkg::*;

   localparam int H = 10;
   localparam int G = 4;

   logic       clk = 1'b0;
   logic       clear;
   logic       rv0, rv1;
   logic [3:0] rk0, rk1;
   logic       rot;
   logic [3:0] so_fix;
   logic [3:0] so;
   logic       rdy0, rdy1, busy0, busy1, done0, done1;
   logic [3:0] sg0, sg1;
   int         cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign so = rot ? (4'b0001 << cyc[1:0]) : so_fix;

   keypad_emulator #(
      .CNT_W(8), .HOLD_CYCLES(H), .GAP_CYCLES(G), .BOUNCE_TOGGLES(0), .BOUNCE_PERIOD(1)
   ) u_clean (
      .clk(clk), .clear(clear), .req_valid(rv0), .req_key(rk0), .req_ready(rdy0),
      .scan_output(so), .scan_got(sg0), .busy(busy0), .done(done0)
   );

   keypad_emulator #(
      .CNT_W(8), .HOLD_CYCLES(H), .GAP_CYCLES(G), .BOUNCE_TOGGLES(3), .BOUNCE_PERIOD(2)
   ) u_bnc (
      .clk(clk), .clear(clear), .req_valid(rv1), .req_key(rk1), .req_ready(rdy1),
      .scan_output(so), .scan_got(sg1), .busy(busy1), .done(done1)
   );

   typedef struct {
      int         dut;
      int         c;
      logic [3:0] v;
   } sg_exp_t;

   sg_exp_t q_sg[$];
   int      q_done0[$];
   int      q_done1[$];
   int      q_hex[$];
   int      checks   = 0;
   int      failures = 0;
   logic    loop_en  = 1'b0;
   logic    held     = 1'b0;

   function automatic void chk(input string n, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", n, act, exp);
      end
   endfunction

   function automatic logic [1:0] oh_idx(input logic [3:0] v);
      for (int i = 0; i < 4; i++)
         if (v[i]) return 2'(i);
      return 2'd0;
   endfunction

   always @(negedge clk) begin
      sg_exp_t    e;
      logic [3:0] hx;
      while (q_sg.size() > 0 && q_sg[0].c <= cyc) begin
         e = q_sg.pop_front();
         if (e.c < cyc)
            chk("scan_got_late_entry", cyc, e.c);
         else
            chk($sformatf("scan_got dut%0d cyc%0d", e.dut, e.c),
                int'(e.dut == 1 ? sg1 : sg0), int'(e.v));
      end
      if (done0) begin
         if (q_done0.size() == 0) chk("done0_unexpected", 1, 0);
         else chk("done0_cycle", cyc, q_done0.pop_front());
      end
      if (done1) begin
         if (q_done1.size() == 0) chk("done1_unexpected", 1, 0);
         else chk("done1_cycle", cyc, q_done1.pop_front());
      end
      // Keypad driver model: reports a key once per closure.
      if (loop_en && !held && sg0 != 4'd0) begin
         hx   = key_to_hex({oh_idx(sg0), oh_idx(so)});
         held = 1'b1;
         if (q_hex.size() == 0) chk("hex_unexpected", int'(hx), -1);
         else chk("hex_key", int'(hx), q_hex.pop_front());
      end
      if (done0) held = 1'b0;
   end

   task automatic press(input int d, input logic [3:0] k, output int a);
      @(negedge clk);
      if (d == 0) begin rv0 = 1'b1; rk0 = k; end
      else        begin rv1 = 1'b1; rk1 = k; end
      @(posedge clk);
      #1;
      a = cyc;
      rv0 = 1'b0;
      rv1 = 1'b0;
   endtask

   task automatic push_sg(input int d, input int c, input logic [3:0] v);
      sg_exp_t e;
      e.dut = d; e.c = c; e.v = v;
      q_sg.push_back(e);
   endtask

   task automatic end_test(input string n);
      chk($sformatf("%s pending_done", n), q_done0.size() + q_done1.size(), 0);
      chk($sformatf("%s pending_scan", n), q_sg.size(), 0);
      chk($sformatf("%s pending_hex", n), q_hex.size(), 0);
      q_done0.delete(); q_done1.delete(); q_sg.delete(); q_hex.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      int a, b;
      logic [3:0] v;
      clear = 1'b1; rv0 = 1'b1; rv1 = 1'b1; rk0 = 4'd7; rk1 = 4'd7;
      rot = 1'b0; so_fix = 4'b1111;

      // Reset with requests pending: clear must win.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_busy0", int'(busy0), 0);
         chk("rst_ready0", int'(rdy0), 1);
         chk("rst_busy1", int'(busy1), 0);
         chk("rst_ready1", int'(rdy1), 1);
         chk("rst_done0", int'(done0), 0);
      end
      clear = 1'b0; rv0 = 1'b0; rv1 = 1'b0;
      @(negedge clk);
      chk("post_rst_busy0", int'(busy0), 0);
      chk("post_rst_ready0", int'(rdy0), 1);
      chk("post_rst_sg0", int'(sg0), 0);
      chk("post_rst_sg1", int'(sg1), 0);

      // Clean press of key 6 with rotating columns.
      rot = 1'b1;
      press(0, 4'd6, a);
      for (int c = a; c <= a + H + G + 1; c++) begin
         v = (c < a + H && (c % 4) == 2) ? 4'b0010 : 4'b0000;
         push_sg(0, c, v);
      end
      q_done0.push_back(a + H + G);
      repeat (H + G + 4) @(posedge clk);
      end_test("clean");

      // Bounce on key 13, column 1 held.
      rot = 1'b0; so_fix = 4'b0010;
      press(1, 4'd13, a);
      for (int c = a; c <= a + 21; c++) begin
         v = (c < a + 2 || (c >= a + 4 && c < a + 16)) ? 4'b1000 : 4'b0000;
         push_sg(1, c, v);
      end
      q_done1.push_back(a + 20);
      repeat (26) @(posedge clk);
      end_test("bounce");

      // Request for key 3 while key 0 is held must be dropped.
      rot = 1'b1;
      press(0, 4'd0, a);
      for (int c = a; c <= a + H + G + 1; c++) begin
         v = (c < a + H && (c % 4) == 0) ? 4'b0001 : 4'b0000;
         push_sg(0, c, v);
      end
      q_done0.push_back(a + H + G);
      repeat (2) @(negedge clk);
      rv0 = 1'b1; rk0 = 4'd3;
      repeat (6) @(negedge clk);
      rv0 = 1'b0;
      repeat (H + G + 4) @(posedge clk);
      end_test("busy_ignore");

      // Clear during the fifth hold cycle, then an immediate new request.
      rot = 1'b0; so_fix = 4'b0010;
      press(0, 4'd5, a);
      for (int c = a; c <= a + 4; c++) push_sg(0, c, 4'b0010);
      push_sg(0, a + 5, 4'b0000);
      repeat (5) @(negedge clk);
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      press(0, 4'd5, b);
      chk("clear_reaccept_cycle", b, a + 6);
      for (int c = b; c <= b + H + G + 1; c++)
         push_sg(0, c, (c < b + H) ? 4'b0010 : 4'b0000);
      q_done0.push_back(b + H + G);
      repeat (H + G + 4) @(posedge clk);
      end_test("clear_mid");

      // Closed loop: driver model decodes keys 1, 5, 14.
      rot = 1'b1; loop_en = 1'b1; held = 1'b0;
      q_hex.push_back(2);
      q_hex.push_back(6);
      q_hex.push_back(14);
      press(0, 4'd1, a);
      q_done0.push_back(a + H + G);
      repeat (H + G + 2) @(posedge clk);
      press(0, 4'd5, a);
      q_done0.push_back(a + H + G);
      repeat (H + G + 2) @(posedge clk);
      press(0, 4'd14, a);
      q_done0.push_back(a + H + G);
      repeat (H + G + 4) @(posedge clk);
      loop_en = 1'b0;
      end_test("closed_loop");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
